// File: rtl/icache_assoc.sv
`default_nettype none
// ============================================================================
// Module   : icache_assoc
// Brief    : Set-associative instruction cache with multi-word lines,
//            per-set round-robin replacement, a refill FSM and flush.
//            The hit path is combinational from pc_in.
// Revision : 1.0 - initial release
// ============================================================================
module icache_assoc #(
  parameter int ADDR_W     = 32,
  parameter int INST_W     = 32,
  parameter int NUM_SETS   = 16,
  parameter int NUM_WAYS   = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              inst_en,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              cache_rdy,
  output logic [INST_W-1:0] inst_out,
  output logic              mem_req_en,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ack,
  input  logic              mem_resp_valid,
  input  logic [INST_W-1:0] mem_resp_data
);

  // Address split: byte offset (word + 2 byte bits), set index, tag.
  localparam int c_WOFF_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int c_OFF    = $clog2(LINE_WORDS) + 2;
  localparam int c_IDX_W  = $clog2(NUM_SETS);
  localparam int c_TAG_W  = ADDR_W - c_OFF - c_IDX_W;
  localparam int c_WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam logic [c_WOFF_W-1:0] c_LAST    = c_WOFF_W'(LINE_WORDS - 1);
  localparam logic [c_WAY_W-1:0]  c_WAY_MAX = c_WAY_W'(NUM_WAYS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_REFILL = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  // Storage
  logic [INST_W-1:0]   r_data  [NUM_WAYS][NUM_SETS][LINE_WORDS];
  logic [c_TAG_W-1:0]  r_tag   [NUM_WAYS][NUM_SETS];
  logic [NUM_SETS-1:0] r_valid [NUM_WAYS];
  logic [c_WAY_W-1:0]  r_rr    [NUM_SETS];

  // Refill control
  state_t              r_state;
  logic                r_req_en;
  logic [ADDR_W-1:0]   r_req_addr;
  logic [c_WAY_W-1:0]  r_victim;
  logic [c_IDX_W-1:0]  r_idx;
  logic [c_TAG_W-1:0]  r_tag_l;
  logic [c_WOFF_W-1:0] r_cnt;

  // Lookup wires
  logic [c_WOFF_W-1:0] w_word;
  logic [c_IDX_W-1:0]  w_idx;
  logic [c_TAG_W-1:0]  w_tag;
  logic                w_hit;
  logic [INST_W-1:0]   w_hit_data;
  logic [c_WAY_W-1:0]  w_victim;
  logic                w_found;
  logic [c_WAY_W-1:0]  w_rr_next;
  logic                w_unused_pc;

  assign w_idx       = pc_in[c_OFF+c_IDX_W-1:c_OFF];
  assign w_tag       = pc_in[ADDR_W-1:c_OFF+c_IDX_W];
  assign w_unused_pc = ^pc_in[1:0];

  generate
    if (LINE_WORDS > 1) begin : g_word_multi
      assign w_word = pc_in[c_OFF-1:2];
    end else begin : g_word_single
      assign w_word = '0;
    end
  endgenerate

  // Tag compare across all ways of the addressed set; at most one way matches.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
        w_hit      = 1'b1;
        w_hit_data = r_data[w][w_idx][w_word];
      end
    end
  end

  // Victim: lowest-numbered invalid way, otherwise the set's round-robin way.
  always_comb begin
    w_victim = r_rr[w_idx];
    w_found  = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!w_found && !r_valid[w][w_idx]) begin
        w_victim = c_WAY_W'(w);
        w_found  = 1'b1;
      end
    end
  end

  assign w_rr_next = (r_rr[r_idx] == c_WAY_MAX) ? '0 : r_rr[r_idx] + 1'b1;

  assign cache_rdy    = inst_en & (r_state == S_IDLE) & w_hit & ~rst_in;
  assign inst_out     = w_hit_data;
  assign mem_req_en   = r_req_en;
  assign mem_req_addr = r_req_addr;

  // Line data write: one word per refill beat into the chosen victim way.
  always_ff @(posedge clk) begin
    if (!rst_in && rdy_in && (r_state == S_REFILL) && mem_resp_valid) begin
      r_data[r_victim][r_idx][r_cnt] <= mem_resp_data;
    end
  end

  // Refill FSM plus valid/tag/round-robin bookkeeping and flush.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      r_req_en   <= 1'b0;
      r_req_addr <= '0;
      r_victim   <= '0;
      r_idx      <= '0;
      r_tag_l    <= '0;
      r_cnt      <= '0;
      for (int w = 0; w < NUM_WAYS; w++) r_valid[w] <= '0;
      for (int s = 0; s < NUM_SETS; s++) r_rr[s] <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        for (int w = 0; w < NUM_WAYS; w++) r_valid[w] <= '0;
      end
      case (r_state)
        S_IDLE: begin
          if (inst_en && !w_hit && !flush_in) begin
            r_req_addr <= {pc_in[ADDR_W-1:c_OFF], {c_OFF{1'b0}}};
            r_idx      <= w_idx;
            r_tag_l    <= w_tag;
            r_victim   <= w_victim;
            r_req_en   <= 1'b1;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ack) begin
            r_req_en <= 1'b0;
            r_cnt    <= '0;
            if (flush_in) begin
              r_state <= S_DRAIN;
            end else begin
              // Old line contents are overwritten from the first beat on.
              r_valid[r_victim][r_idx] <= 1'b0;
              r_state                  <= S_REFILL;
            end
          end
        end
        S_REFILL: begin
          if (mem_resp_valid) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_LAST) begin
              r_state <= S_IDLE;
              // A flush on the final beat leaves the line invalid.
              if (!flush_in) begin
                r_valid[r_victim][r_idx] <= 1'b1;
                r_tag[r_victim][r_idx]   <= r_tag_l;
                r_rr[r_idx]              <= w_rr_next;
              end
            end else if (flush_in) begin
              r_state <= S_DRAIN;
            end
          end else if (flush_in) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (mem_resp_valid) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_LAST) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_assoc.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_assoc
// Brief    : Directed self-checking bench for icache_assoc (default geometry
//            plus a 4-way / 8-word / 8-set instance for replacement order).
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_assoc;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, flush_in;
  logic        inst_en0, inst_en6;
  logic [31:0] pc_in;
  logic        mem_req_ack, mem_resp_valid;
  logic [31:0] mem_resp_data;

  logic        rdy0, rdy6, req0, req6;
  logic [31:0] inst0, inst6, addr0, addr6;

  logic        sel;
  logic        w_rdy, w_req;
  logic [31:0] w_inst, w_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign w_rdy  = sel ? rdy6  : rdy0;
  assign w_req  = sel ? req6  : req0;
  assign w_inst = sel ? inst6 : inst0;
  assign w_addr = sel ? addr6 : addr0;

  icache_assoc u_dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .inst_en(inst_en0), .pc_in(pc_in), .cache_rdy(rdy0), .inst_out(inst0),
    .mem_req_en(req0), .mem_req_addr(addr0), .mem_req_ack(mem_req_ack),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  icache_assoc #(.NUM_SETS(8), .NUM_WAYS(4), .LINE_WORDS(8)) u_dut6 (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .inst_en(inst_en6), .pc_in(pc_in), .cache_rdy(rdy6), .inst_out(inst6),
    .mem_req_en(req6), .mem_req_addr(addr6), .mem_req_ack(mem_req_ack),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  // Memory contents: each word is its own byte address XOR a fixed pattern.
  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'hD000_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_en(input logic v);
    if (sel) inst_en6 = v;
    else     inst_en0 = v;
  endtask

  task automatic wait_req(input string tag, input logic [31:0] a);
    int n = 0;
    while (!w_req && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, {31'd0, w_req}, 32'd1);
    chk({tag, "_addr"}, w_addr, a);
  endtask

  task automatic do_ack(input string tag, input logic f);
    mem_req_ack = 1'b1;
    flush_in    = f;
    tick();
    mem_req_ack = 1'b0;
    flush_in    = 1'b0;
    chk({tag, "_req_drop"}, {31'd0, w_req}, 32'd0);
  endtask

  task automatic beats(input logic [31:0] base, input int n, input int flush_at);
    for (int i = 0; i < n; i++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = memw(base + 32'(4 * i));
      flush_in       = (i == flush_at);
      tick();
    end
    mem_resp_valid = 1'b0;
    flush_in       = 1'b0;
  endtask

  task automatic fill(input string tag, input logic [31:0] pc, input logic [31:0] line, input int n);
    pc_in = pc;
    set_en(1'b1);
    #1;
    chk({tag, "_miss"}, {31'd0, w_rdy}, 32'd0);
    wait_req(tag, line);
    do_ack(tag, 1'b0);
    beats(line, n, -1);
    #1;
    chk({tag, "_hit"}, {31'd0, w_rdy}, 32'd1);
    chk({tag, "_data"}, w_inst, memw(pc));
  endtask

  initial begin
    sel = 1'b0;
    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0;
    inst_en0 = 1'b0; inst_en6 = 1'b0; pc_in = 32'h0;
    mem_req_ack = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
    tick();
    tick();

    // Reset state
    inst_en0 = 1'b1;
    pc_in    = 32'h0000_1004;
    #1;
    chk("rst_rdy", {31'd0, rdy0}, 32'd0);
    chk("rst_req", {31'd0, req0}, 32'd0);
    chk("rst_addr", addr0, 32'h0);
    rst_in = 1'b0;

    // 1: cold miss, then another word of the same line
    fill("t1", 32'h0000_1004, 32'h0000_1000, 4);
    pc_in = 32'h0000_100C;
    #1;
    chk("t1_w3_hit", {31'd0, rdy0}, 32'd1);
    chk("t1_w3_data", inst0, 32'hD000_100C);
    tick();
    chk("t1_no_req", {31'd0, req0}, 32'd0);

    // 2: conflict in set 0
    fill("t2a", 32'h0000_2000, 32'h0000_2000, 4);
    pc_in = 32'h0000_1000;
    #1;
    chk("t2_1000_hit", {31'd0, rdy0}, 32'd1);
    chk("t2_1000_data", inst0, 32'hD000_1000);
    fill("t2b", 32'h0000_3000, 32'h0000_3000, 4);
    pc_in = 32'h0000_2000;
    #1;
    chk("t2_2000_hit", {31'd0, rdy0}, 32'd1);
    chk("t2_2000_data", inst0, 32'hD000_2000);
    pc_in = 32'h0000_1000;
    #1;
    chk("t2_1000_evicted", {31'd0, rdy0}, 32'd0);

    // 3: flush during the second refill beat of 0x1000
    wait_req("t3", 32'h0000_1000);
    do_ack("t3", 1'b0);
    beats(32'h0000_1000, 4, 1);
    chk("t3_req_quiet", {31'd0, req0}, 32'd0);
    #1;
    chk("t3_after_miss", {31'd0, rdy0}, 32'd0);
    wait_req("t3_rereq", 32'h0000_1000);
    do_ack("t3_rereq", 1'b0);
    beats(32'h0000_1000, 4, -1);
    #1;
    chk("t3_refilled_hit", {31'd0, rdy0}, 32'd1);
    chk("t3_refilled_data", inst0, 32'hD000_1000);

    // 4: flush coincident with the request acknowledge
    pc_in = 32'h0000_3000;
    #1;
    chk("t4_miss", {31'd0, rdy0}, 32'd0);
    wait_req("t4", 32'h0000_3000);
    do_ack("t4", 1'b1);
    beats(32'h0000_3000, 4, -1);
    pc_in = 32'h0000_1000;
    #1;
    chk("t4_1000_miss", {31'd0, rdy0}, 32'd0);
    pc_in = 32'h0000_3000;
    #1;
    chk("t4_3000_miss", {31'd0, rdy0}, 32'd0);
    inst_en0 = 1'b0;
    tick();
    chk("t4_idle_req", {31'd0, req0}, 32'd0);

    // 5: rdy_in low for three cycles while a request is pending
    inst_en0 = 1'b1;
    pc_in    = 32'h0000_2008;
    #1;
    chk("t5_miss", {31'd0, rdy0}, 32'd0);
    wait_req("t5", 32'h0000_2000);
    rdy_in      = 1'b0;
    mem_req_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_frozen_req", {31'd0, req0}, 32'd1);
      chk("t5_frozen_addr", addr0, 32'h0000_2000);
    end
    rdy_in = 1'b1;
    tick();
    mem_req_ack = 1'b0;
    chk("t5_req_drop", {31'd0, req0}, 32'd0);
    beats(32'h0000_2000, 4, -1);
    #1;
    chk("t5_hit", {31'd0, rdy0}, 32'd1);
    chk("t5_data", inst0, 32'hD000_2008);
    inst_en0 = 1'b0;
    tick();

    // 6: 4-way, 8-word lines, 8 sets; five lines into set 3 (pc[7:5]=3)
    sel = 1'b1;
    fill("t6_0", 32'h0000_0074, 32'h0000_0060, 8);
    fill("t6_1", 32'h0000_0174, 32'h0000_0160, 8);
    fill("t6_2", 32'h0000_0274, 32'h0000_0260, 8);
    fill("t6_3", 32'h0000_0374, 32'h0000_0360, 8);
    fill("t6_4", 32'h0000_0464, 32'h0000_0460, 8);
    pc_in = 32'h0000_0074;
    #1;
    chk("t6_way0_evicted", {31'd0, rdy6}, 32'd0);
    pc_in = 32'h0000_0178;
    #1;
    chk("t6_way1_data", inst6, 32'hD000_0178);
    chk("t6_way1_hit", {31'd0, rdy6}, 32'd1);
    pc_in = 32'h0000_027C;
    #1;
    chk("t6_way2_hit", {31'd0, rdy6}, 32'd1);
    pc_in = 32'h0000_0360;
    #1;
    chk("t6_way3_data", inst6, 32'hD000_0360);
    inst_en6 = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
